// File: rtl/uart_tx_io_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_io_if
// Purpose  : CPU-side write/status bundle for the memory-mapped UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_io_if #(
    parameter int AW = 3
) ();
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          clr_overflow;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic          busy;
    logic          overflow;

    // The CPU/MEM_IO side drives writes and reads status.
    modport master (
        output wr_en, wr_data, clr_overflow,
        input  fifo_full, fifo_empty, fifo_count, busy, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_overflow,
        output fifo_full, fifo_empty, fifo_count, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_io.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_io
// Purpose  : FIFO-buffered 8N1 UART transmitter with polled status and sticky overflow.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_io #(
    parameter int CLKS_PER_BIT = 781,
    parameter int FIFO_DEPTH   = 8,
    parameter int AW           = 3
) (
    input  wire logic     clock,
    input  wire logic     reset,
    uart_tx_io_if.slave   bus,
    output logic          tx,
    output logic          tx_done
);
    localparam int            c_baud_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_last_tick = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   c_depth     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic                r_full;
    logic                r_empty;
    logic                r_overflow;

    state_t              r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                r_tx_done;

    logic                w_accept;
    logic                w_pop;
    logic                w_bit_end;
    logic [AW:0]         w_count_next;

    // Acceptance uses the registered full flag, so a same-cycle pop cannot rescue a write.
    assign w_accept  = bus.wr_en & ~r_full;
    assign w_pop     = (r_state == S_IDLE) & ~r_empty;
    assign w_bit_end = (r_baud == c_last_tick);

    always_comb begin
        w_count_next = r_count;
        case ({w_accept, w_pop})
            2'b10:   w_count_next = r_count + (AW + 1)'(1);
            2'b01:   w_count_next = r_count - (AW + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_depth);
            r_empty <= (w_count_next == '0);
            // A dropped write outranks a simultaneous clear.
            if (bus.wr_en & r_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // tx and tx_done are registered from the current state, so both trail the
    // FSM by one cycle; tx_done thus lines up with the final stop-bit cycle on tx.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase

            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_tx_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + c_baud_w'(1);
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx             = r_tx;
    assign tx_done        = r_tx_done;
    assign bus.fifo_full  = r_full;
    assign bus.fifo_empty = r_empty;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.busy       = (r_state != S_IDLE) | ~r_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_io
// Purpose  : Directed self-checking bench for uart_tx_io (4 clocks/bit, 4-entry FIFO).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_io;
    localparam int CLKS_PER_BIT = 4;
    localparam int FIFO_DEPTH   = 4;
    localparam int AW           = 2;

    logic clock = 1'b0;
    logic reset;
    logic tx;
    logic tx_done;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_tx_io_if #(.AW(AW)) bus ();

    uart_tx_io #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .AW           (AW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .tx      (tx),
        .tx_done (tx_done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    // Frame position k=0 is the first cycle tx is low; each bit spans 4 cycles.
    task automatic check_frame(input logic [7:0] d, input int k0);
        logic e;
        for (int k = k0; k < 40; k++) begin
            if (k < 4)       e = 1'b0;
            else if (k < 36) e = d[(k - 4) / 4];
            else             e = 1'b1;
            check_eq($sformatf("tx_%02h_k%0d", d, k), tx, e);
            check_eq($sformatf("done_%02h_k%0d", d, k), tx_done, (k == 39));
            tick();
        end
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        int lows  = 0;
        int dones = 0;
        for (int i = 0; i < cycles; i++) begin
            if (!tx) lows++;
            if (tx_done) dones++;
            tick();
        end
        check_eq({tag, "_tx_low"}, lows, 0);
        check_eq({tag, "_done"}, dones, 0);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_tx"}, tx, 1'b1);
        check_eq({tag, "_empty"}, bus.fifo_empty, 1'b1);
        check_eq({tag, "_full"}, bus.fifo_full, 1'b0);
        check_eq({tag, "_count"}, bus.fifo_count, 0);
        check_eq({tag, "_busy"}, bus.busy, 1'b0);
        check_eq({tag, "_done"}, tx_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b_data [3]   = '{8'h00, 8'hFF, 8'h3C};
        int         b2b_cnt  [3]   = '{1, 1, 2};
        int         ov_cnt   [6]   = '{1, 1, 2, 3, 4, 4};
        logic       ov_full  [6]   = '{0, 0, 0, 0, 1, 1};
        logic       ov_flag  [6]   = '{0, 0, 0, 0, 0, 1};
        int         fp_cnt   [5]   = '{1, 1, 2, 3, 4};

        reset            = 1'b1;
        bus.wr_en        = 1'b0;
        bus.wr_data      = 8'h00;
        bus.clr_overflow = 1'b0;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("rst%0d", i));
            check_eq($sformatf("rst%0d_ovf", i), bus.overflow, 1'b0);
        end
        reset = 1'b0;
        tick();

        // Single byte 0xA5.
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        check_eq("single_count", bus.fifo_count, 1);
        check_eq("single_empty", bus.fifo_empty, 1'b0);
        check_eq("single_busy", bus.busy, 1'b1);
        check_eq("single_tx_w0", tx, 1'b1);
        tick();
        check_eq("single_tx_w1", tx, 1'b1);
        check_eq("single_popped", bus.fifo_count, 0);
        check_eq("single_busy_pop", bus.busy, 1'b1);
        tick();
        check_frame(8'hA5, 0);
        check_idle("single_end");

        // Back-to-back: pop happens on the second write edge, so counts are 1,1,2.
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = b2b_data[i];
            tick();
            check_eq($sformatf("b2b_count%0d", i), bus.fifo_count, b2b_cnt[i]);
        end
        bus.wr_en = 1'b0;
        check_frame(8'h00, 0);
        check_eq("b2b_gap1_tx", tx, 1'b1);
        check_eq("b2b_gap1_count", bus.fifo_count, 1);
        tick();
        check_frame(8'hFF, 0);
        check_eq("b2b_gap2_tx", tx, 1'b1);
        check_eq("b2b_gap2_count", bus.fifo_count, 0);
        tick();
        check_frame(8'h3C, 0);
        check_idle("b2b_end");

        // Overflow: six writes into a 4-deep FIFO with one pop.
        for (int i = 0; i < 6; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'h11 + 8'(i);
            tick();
            check_eq($sformatf("ovf_count%0d", i), bus.fifo_count, ov_cnt[i]);
            check_eq($sformatf("ovf_full%0d", i), bus.fifo_full, ov_full[i]);
            check_eq($sformatf("ovf_flag%0d", i), bus.overflow, ov_flag[i]);
        end
        bus.wr_en = 1'b0;
        check_frame(8'h11, 3);
        for (int i = 1; i < 5; i++) begin
            tick();
            check_frame(8'h11 + 8'(i), 0);
        end
        check_quiet("ovf_after", 60);
        check_eq("ovf_sticky", bus.overflow, 1'b1);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check_eq("ovf_cleared", bus.overflow, 1'b0);

        // Fill during a frame, then write (with a clear) on the pop cycle.
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'h21 + 8'(i);
            tick();
            check_eq($sformatf("fp_count%0d", i), bus.fifo_count, fp_cnt[i]);
        end
        bus.wr_en = 1'b0;
        check_eq("fp_full", bus.fifo_full, 1'b1);
        repeat (37) tick();
        check_eq("fp_last_stop_done", tx_done, 1'b1);
        check_eq("fp_pre_count", bus.fifo_count, 4);
        bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.clr_overflow = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.clr_overflow = 1'b0;
        check_eq("fp_post_count", bus.fifo_count, 3);
        check_eq("fp_ovf_set_wins", bus.overflow, 1'b1);
        check_eq("fp_not_full", bus.fifo_full, 1'b0);
        tick();
        check_frame(8'h22, 0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("fp_reset");
        check_eq("fp_reset_ovf", bus.overflow, 1'b0);
        tick();

        // Reset during data bit 3 with two bytes still queued.
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'h31 + 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        check_eq("mid_queued", bus.fifo_count, 2);
        repeat (17) tick();
        check_eq("mid_bit3", tx, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("mid_reset");
        check_quiet("mid_after", 60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
